// File: rtl/cp2_fdata_receiver.sv
// cp2_fdata_receiver
// Receives the registered CP2 fdata strobe stream, buffers words in a small
// FIFO and hands them one at a time to a downstream writer over req/ack.
// The producer is never stalled: words arriving while full are dropped and
// recorded in a sticky overflow flag.

// Bus-width and reset-polarity macros normally come from bus.vh; fall back
// to the standard CP2 values when that header has not been pulled in.
`ifndef WORDDATAW
`define WORDDATAW 32
`endif
`ifndef WORDDATABUS
`define WORDDATABUS 31:0
`endif
`ifndef RESET_EDGE
`define RESET_EDGE negedge
`endif
`ifndef RESET_ENABLE
`define RESET_ENABLE 1'b0
`endif

module cp2_fdata_receiver #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk_,
    input  logic                rst,
    input  logic                cp2_fds_0,
    input  logic [`WORDDATABUS] cp2_fdata_0,
    input  logic                flush,
    input  logic                wr_ack,
    output logic                wr_req,
    output logic [`WORDDATABUS] wr_data,
    output logic [AW:0]         fifo_count,
    output logic                overflow,
    output logic                busy
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0] TWO_CNT  = (AW+1)'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [`WORDDATABUS] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]         count_reg, count_next;
    logic                overflow_reg;
    logic                wr_req_reg, wr_req_next;
    logic [`WORDDATABUS] wr_data_reg;

    logic                full;
    logic                push;
    logic                drop;
    logic                pop;
    logic                load_en;
    logic [AW-1:0]       rd_addr;

    // Fullness is judged on the pre-pop count, so a word arriving while full
    // is dropped even if the head is popped in the same cycle. Flush wins
    // over both push and pop.
    assign full = (count_reg == FULL_CNT);
    assign push = cp2_fds_0 & ~full & ~flush;
    assign drop = cp2_fds_0 &  full & ~flush;
    assign pop  = (state_reg == ST_REQ) & wr_ack & ~flush;

    // State register
    always_ff @(posedge clk_ or `RESET_EDGE rst) begin
        if (rst == `RESET_ENABLE) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: request while data is queued, return to idle once
    // the last queued word is acknowledged.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (count_reg != '0) state_next = ST_REQ;
                ST_REQ:  if (wr_ack && (count_reg == ONE_CNT)) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output logic: decide when to fetch the next word and where from.
    // In REQ the presented word is still at rd_ptr, so the follow-on word
    // for a back-to-back transfer sits at rd_ptr+1.
    always_comb begin
        load_en     = 1'b0;
        rd_addr     = rd_ptr_reg;
        wr_req_next = wr_req_reg;
        if (flush) begin
            wr_req_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (count_reg != '0) begin
                        load_en     = 1'b1;
                        wr_req_next = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (wr_ack) begin
                        if (count_reg >= TWO_CNT) begin
                            load_en = 1'b1;
                            rd_addr = rd_ptr_reg + AW'(1);
                        end else begin
                            wr_req_next = 1'b0;
                        end
                    end
                end
                default: wr_req_next = 1'b0;
            endcase
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, cleared by flush.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + ONE_CNT;
        end else if (pop && !push) begin
            count_next = count_reg - ONE_CNT;
        end
    end

    // FIFO storage write port; no reset so it maps onto RAM.
    always_ff @(posedge clk_) begin
        if (push) begin
            mem[wr_ptr_reg] <= cp2_fdata_0;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered write port.
    // Reads never collide with the same-cycle write: the written slot is
    // rd_ptr+count, which differs from both read addresses whenever a read
    // is issued.
    always_ff @(posedge clk_ or `RESET_EDGE rst) begin
        if (rst == `RESET_ENABLE) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            wr_req_reg   <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            count_reg  <= count_next;
            wr_req_reg <= wr_req_next;
            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                if (drop) overflow_reg <= 1'b1;
            end
            if (load_en) begin
                wr_data_reg <= mem[rd_addr];
            end
        end
    end

    assign wr_req     = wr_req_reg;
    assign wr_data    = wr_data_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign busy       = (count_reg != '0) | wr_req_reg;

endmodule
